spm_mem_rob: RTL and testbench

//  Memory reorder buffer between spm_arbiter's fetch port and the DCP NoC memory interface.
//  - Accepts tagged read requests from the arbiter.
//  - Assigns each request a free slot and uses the slot index as the NoC transid.
//  - Captures NoC responses, which may arrive out of order and cannot be stalled.
//  - Returns responses to the arbiter strictly in request order, carrying the arbiter's own tag.

---
 rtl/spm_pkg.sv | 14 +
 rtl/spm_rob_ptr.sv | 29 ++
 rtl/spm_mem_rob.sv | 73 +++++++
 tb/tb_spm_mem_rob.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// spm_pkg: shared widths and slot record for the SPM memory reorder buffer
package spm_pkg;
  localparam int SPM_ROB_SLOT_W = 3;
  localparam int SPM_TAG_W = 6;
  localparam int SPM_TID_W = 6;
  localparam int SPM_ADDR_W = 40;
  localparam int SPM_DATA_W = 64;
  typedef struct packed {
    logic [SPM_TAG_W-1:0] tag;
    logic [SPM_DATA_W-1:0] data;
    logic pend;
    logic done;
  } rob_slot_t;
endpackage

// File: rtl/spm_rob_ptr.sv
// spm_rob_ptr: wrapping head/tail pointers with occupancy count, full and empty
module spm_rob_ptr #(
  parameter int SLOT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output logic [SLOT_W-1:0] head,
  output logic [SLOT_W-1:0] tail,
  output logic [SLOT_W:0]   count,
  output logic              full,
  output logic              empty
);
  assign full = count == (SLOT_W+1)'(2**SLOT_W);
  assign empty = count == '0;
  // pointers wrap naturally at the slot count; count tracks issue minus drain
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      tail <= tail + SLOT_W'(inc);
      head <= head + SLOT_W'(dec);
      count <= count + (SLOT_W+1)'(inc) - (SLOT_W+1)'(dec);
    end
  end
endmodule

// File: rtl/spm_mem_rob.sv
// spm_mem_rob: reorders out-of-order NoC read responses back into arbiter request order
module spm_mem_rob
  import spm_pkg::*;
#(
  parameter int SLOT_W = SPM_ROB_SLOT_W,
  parameter int TAG_W = SPM_TAG_W,
  parameter int TID_W = SPM_TID_W,
  parameter int ADDR_W = SPM_ADDR_W,
  parameter int DATA_W = SPM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              noc_req_val,
  input  logic              noc_req_rdy,
  output logic [ADDR_W-1:0] noc_req_addr,
  output logic [TID_W-1:0]  noc_req_transid,
  input  logic              noc_resp_val,
  input  logic [TID_W-1:0]  noc_resp_transid,
  input  logic [DATA_W-1:0] noc_resp_data,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_data,
  output logic [SLOT_W:0]   outstanding,
  output logic              err_spurious
);
  localparam int SLOTS = 2**SLOT_W;
  rob_slot_t slots [SLOTS];
  logic [SLOT_W-1:0] head, tail, cap_idx;
  logic full, empty, issue, drain, cap_ok;
  spm_rob_ptr #(.SLOT_W(SLOT_W)) u_ptr (
    .clk(clk), .rst(rst), .inc(issue), .dec(drain),
    .head(head), .tail(tail), .count(outstanding), .full(full), .empty(empty)
  );
  assign noc_req_val = req_val & ~full;
  assign req_rdy = noc_req_rdy & ~full;
  assign noc_req_addr = req_addr;
  assign noc_req_transid = TID_W'(tail);
  assign issue = req_val & req_rdy;
  assign cap_idx = noc_resp_transid[SLOT_W-1:0];
  assign cap_ok = noc_resp_val & ~|(noc_resp_transid >> SLOT_W) & slots[cap_idx].pend;
  assign out_val = ~empty & slots[head].done;
  assign out_tag = slots[head].tag;
  assign out_data = slots[head].data;
  assign drain = out_val & out_rdy;
  // issue, capture and drain always address distinct slots, so their updates never collide
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
    end else begin
      if (issue) begin
        slots[tail].tag <= req_tag;
        slots[tail].pend <= 1'b1;
        slots[tail].done <= 1'b0;
      end
      if (cap_ok) begin
        slots[cap_idx].data <= noc_resp_data;
        slots[cap_idx].pend <= 1'b0;
        slots[cap_idx].done <= 1'b1;
      end
      if (drain) slots[head].done <= 1'b0;
    end
  end
  // any response not answering a pending slot is dropped and flagged until reset
  always_ff @(posedge clk) begin
    if (rst) err_spurious <= 1'b0;
    else if (noc_resp_val & ~cap_ok) err_spurious <= 1'b1;
  end
endmodule

// File: tb/tb_spm_mem_rob.sv
// tb_spm_mem_rob: directed checks of issue, reorder, full, wrap, stall, spurious and reset
module tb_spm_mem_rob;
  logic clk = 0, rst = 1;
  logic req_val = 0, req_rdy, noc_req_val, noc_req_rdy = 1, noc_resp_val = 0;
  logic out_val, out_rdy = 0, err_spurious;
  logic [39:0] req_addr = 0, noc_req_addr;
  logic [5:0] req_tag = 0, noc_req_transid, noc_resp_transid = 0, out_tag;
  logic [63:0] noc_resp_data = 0, out_data;
  logic [3:0] outstanding;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  spm_mem_rob dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(req_rdy), .req_addr(req_addr),
    .req_tag(req_tag), .noc_req_val(noc_req_val), .noc_req_rdy(noc_req_rdy),
    .noc_req_addr(noc_req_addr), .noc_req_transid(noc_req_transid),
    .noc_resp_val(noc_resp_val), .noc_resp_transid(noc_resp_transid),
    .noc_resp_data(noc_resp_data), .out_val(out_val), .out_rdy(out_rdy), .out_tag(out_tag),
    .out_data(out_data), .outstanding(outstanding), .err_spurious(err_spurious)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask
  task automatic issue(input logic [5:0] t, input logic [5:0] exp_tid);
    req_val = 1;
    req_tag = t;
    #1 chk("issue_tid", noc_req_transid, exp_tid);
    tick();
    req_val = 0;
  endtask
  task automatic respond(input logic [5:0] tid, input logic [63:0] d);
    noc_resp_val = 1;
    noc_resp_transid = tid;
    noc_resp_data = d;
    tick();
    noc_resp_val = 0;
  endtask
  logic [63:0] held;
  initial begin
    #1;
    do_reset();
    chk("rst_out_val", out_val, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_spurious, 0);
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_noc_req_val", noc_req_val, 0);
    // single read
    req_val = 1;
    req_addr = 40'h1000;
    req_tag = 5;
    #1;
    chk("t1_noc_val", noc_req_val, 1);
    chk("t1_addr", noc_req_addr, 40'h1000);
    chk("t1_tid", noc_req_transid, 0);
    tick();
    req_val = 0;
    chk("t1_outstanding", outstanding, 1);
    noc_resp_val = 1;
    noc_resp_transid = 0;
    noc_resp_data = 64'hA5A5A5A5A5A5A5A5;
    #1 chk("t1_no_bypass", out_val, 0);
    tick();
    noc_resp_val = 0;
    chk("t1_out_val", out_val, 1);
    chk("t1_out_tag", out_tag, 5);
    chk("t1_out_data", out_data, 64'hA5A5A5A5A5A5A5A5);
    out_rdy = 1;
    tick();
    out_rdy = 0;
    chk("t1_drained", out_val, 0);
    chk("t1_empty", outstanding, 0);
    // reorder
    do_reset();
    issue(1, 0);
    issue(2, 1);
    issue(3, 2);
    respond(2, 64'h22);
    chk("t2_wait_head", out_val, 0);
    respond(0, 64'h11);
    chk("t2_val0", out_val, 1);
    chk("t2_tag0", out_tag, 1);
    chk("t2_data0", out_data, 64'h11);
    out_rdy = 1;
    respond(1, 64'h21);
    chk("t2_tag1", out_tag, 2);
    chk("t2_data1", out_data, 64'h21);
    tick();
    chk("t2_tag2", out_tag, 3);
    chk("t2_data2", out_data, 64'h22);
    tick();
    out_rdy = 0;
    chk("t2_done", out_val, 0);
    chk("t2_empty", outstanding, 0);
    // full
    do_reset();
    for (int i = 0; i < 8; i++) issue(6'(10 + i), 6'(i));
    req_val = 1;
    #1;
    chk("t3_count", outstanding, 8);
    chk("t3_req_rdy", req_rdy, 0);
    chk("t3_noc_val", noc_req_val, 0);
    req_val = 0;
    respond(0, 64'h77);
    req_val = 1;
    out_rdy = 1;
    #1 chk("t3_no_bypass", req_rdy, 0);
    tick();
    out_rdy = 0;
    req_val = 0;
    chk("t3_count7", outstanding, 7);
    chk("t3_rdy_back", req_rdy, 1);
    // backpressure and wrap
    do_reset();
    issue(40, 0);
    respond(0, 64'hCAFE0000BEEF1234);
    for (int i = 0; i < 10; i++) tick();
    chk("t4_hold_val", out_val, 1);
    chk("t4_hold_tag", out_tag, 40);
    chk("t4_hold_data", out_data, 64'hCAFE0000BEEF1234);
    out_rdy = 1;
    tick();
    out_rdy = 0;
    for (int i = 0; i < 20; i++) begin
      issue(6'(i), 6'((i + 1) % 8));
      respond(6'((i + 1) % 8), 64'(i * 3));
      chk("t4_tag", out_tag, 6'(i));
      chk("t4_data", out_data, 64'(i * 3));
      out_rdy = 1;
      tick();
      out_rdy = 0;
    end
    chk("t4_empty", outstanding, 0);
    // simultaneous issue/drain and NoC stall
    do_reset();
    for (int i = 0; i < 4; i++) issue(6'(i), 6'(i));
    respond(0, 64'h5);
    req_val = 1;
    req_tag = 9;
    out_rdy = 1;
    tick();
    req_val = 0;
    out_rdy = 0;
    chk("t5_count", outstanding, 4);
    chk("t5_head_pending", out_val, 0);
    noc_req_rdy = 0;
    req_val = 1;
    #1;
    chk("t5_stall_rdy", req_rdy, 0);
    chk("t5_stall_noc_val", noc_req_val, 1);
    tick();
    req_val = 0;
    noc_req_rdy = 1;
    chk("t5_no_alloc", outstanding, 4);
    chk("t5_next_tid", noc_req_transid, 5);
    // spurious and reset mid-flight
    do_reset();
    issue(7, 0);
    respond(0, 64'h1234);
    respond(3, 64'hDEAD);
    chk("t6_err", err_spurious, 1);
    chk("t6_val", out_val, 1);
    chk("t6_tag", out_tag, 7);
    chk("t6_data", out_data, 64'h1234);
    chk("t6_count", outstanding, 1);
    issue(8, 1);
    do_reset();
    chk("t6_rst_val", out_val, 0);
    chk("t6_rst_count", outstanding, 0);
    chk("t6_rst_err", err_spurious, 0);
    respond(1, 64'hBAD);
    chk("t6_late_err", err_spurious, 1);
    chk("t6_late_val", out_val, 0);
    do_reset();
    issue(9, 0);
    held = 64'h99;
    respond(8, held);
    chk("t6_hi_err", err_spurious, 1);
    chk("t6_hi_val", out_val, 0);
    chk("t6_hi_count", outstanding, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
